// File: rtl/mul_result_fifo.sv
// Result capture FIFO behind the 4x4 sequential multiplier.
// Optional accumulator enabled with `define MUL_RES_ACC_EN.
module mul_result_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_in,
    input  logic [DATA_W-1:0]        op_in,
    output logic [DATA_W-1:0]        res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef MUL_RES_ACC_EN
    ,
    output logic [DATA_W+7:0]        acc_sum,
    input  logic                     acc_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(LATENCY);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            push;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_d;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   left;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            drop;

    // State and capture timer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state: a new start always restarts the countdown
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_WAIT;
                    timer_d = TW'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (start_in) begin
                    timer_d = TW'(LATENCY - 1);
                end else if (timer_q == '0) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
        endcase
    end

    assign busy      = (state_q == S_WAIT);
    assign res_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = res_valid & res_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign count_d   = count + CW'(wr_en) - CW'(pop);
    assign rd_d      = rd_ptr + AW'(pop);
    assign left      = count - CW'(pop);

    // Storage array; written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= op_in;
        end
    end

    // Pointers, occupancy, sticky overflow and registered head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            res_data <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr_en);
            rd_ptr   <= rd_d;
            count    <= count_d;
            overflow <= overflow | drop;
            if (count_d != '0) begin
                res_data <= (left == '0) ? op_in : mem[rd_d];
            end
        end
    end

`ifdef MUL_RES_ACC_EN
    logic [DATA_W+7:0] pop_ext;
    assign pop_ext = {8'b0, res_data};

    // Running sum of consumed products
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_sum <= '0;
        end else if (pop) begin
            acc_sum <= acc_clr ? pop_ext : acc_sum + pop_ext;
        end else if (acc_clr) begin
            acc_sum <= '0;
        end
    end
`endif

endmodule
